rtc_bus_master: RTL and testbench

- Parametrised command-driven master for a multiplexed address/data RTC bus in Intel mode, with active-low ad (address strobe), cs, wr and rd.
- Replaces hard-coded write sequencers. Any client issues single read or write transactions through a valid/ready command port and receives a response pulse, plus read data.
- Sits between control FSMs (init, time-set, time-read) and the FPGA pins driving the RTC chip.

---
 rtl/rtc_bus_master.sv | 164 ++++++++++++++++
 tb/tb_rtc_bus_master.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_bus_master.sv
// Command-driven master for a multiplexed address/data RTC bus (Intel mode, active-low strobes).
// One read or write per accepted command; response pulse after the data-phase recovery time.
module rtc_bus_master #(
  parameter int                DATA_W   = 8,
  parameter int                T_STB    = 5,
  parameter int                T_GAP    = 8,
  parameter int                T_REC    = 8,
  parameter logic [DATA_W-1:0] IDLE_VAL = '1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [DATA_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic [DATA_W-1:0] ad_out,
  output logic              ad_oe,
  input  logic [DATA_W-1:0] ad_in,
  output logic              ad,
  output logic              cs,
  output logic              wr,
  output logic              rd
);

  typedef enum logic [3:0] {
    IDLE, A_CS, A_STB, A_WRH, A_CSH, A_REL, GAP, D_CS, D_STB, D_CSH, REC
  } state_t;

  localparam logic [5:0] STB_LAST = 6'(T_STB - 1);
  localparam logic [5:0] GAP_LAST = 6'(T_GAP - 1);
  localparam logic [5:0] REC_LAST = 6'(T_REC - 1);
  localparam logic [5:0] ACS_LAST = 6'd1;

  state_t              state_q, state_d;
  logic [5:0]          cnt_q, cnt_d;
  logic                write_q, write_d;
  logic [DATA_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                accept;

  assign accept = cmd_valid && (state_q == IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cmd_valid)            state_d = A_CS;
      A_CS:    if (cnt_q == ACS_LAST)    state_d = A_STB;
      A_STB:   if (cnt_q == STB_LAST)    state_d = A_WRH;
      A_WRH:                             state_d = A_CSH;
      A_CSH:                             state_d = A_REL;
      A_REL:                             state_d = GAP;
      GAP:     if (cnt_q == GAP_LAST)    state_d = D_CS;
      D_CS:                              state_d = D_STB;
      D_STB:   if (cnt_q == STB_LAST)    state_d = D_CSH;
      D_CSH:                             state_d = REC;
      REC:     if (cnt_q == REC_LAST)    state_d = IDLE;
      default:                           state_d = IDLE;
    endcase
  end

  // Counter restarts on every state change so each state times itself from zero.
  always_comb begin
    cnt_d       = (state_d != state_q || state_q == IDLE) ? 6'd0 : cnt_q + 6'd1;
    write_d     = accept ? cmd_write : write_q;
    addr_d      = accept ? cmd_addr  : addr_q;
    wdata_d     = accept ? cmd_wdata : wdata_q;
    rsp_valid_d = (state_q == REC) && (state_d == IDLE);
    rdata_d     = rdata_q;
    if (state_q == D_STB && state_d == D_CSH && !write_q)
      rdata_d = ad_in;
  end

  // The address phase always strobes wr; only the data phase picks wr or rd.
  always_comb begin
    ad     = 1'b1;
    cs     = 1'b1;
    wr     = 1'b1;
    rd     = 1'b1;
    ad_oe  = 1'b0;
    ad_out = IDLE_VAL;
    unique case (state_q)
      A_CS: begin
        ad = 1'b0;
        cs = (cnt_q == 6'd0);
      end
      A_STB: begin
        ad     = 1'b0;
        cs     = 1'b0;
        wr     = 1'b0;
        ad_oe  = 1'b1;
        ad_out = addr_q;
      end
      A_WRH: begin
        ad     = 1'b0;
        cs     = 1'b0;
        ad_oe  = 1'b1;
        ad_out = addr_q;
      end
      A_CSH: begin
        ad     = 1'b0;
        ad_oe  = 1'b1;
        ad_out = addr_q;
      end
      A_REL: begin
        ad_oe  = 1'b1;
        ad_out = addr_q;
      end
      D_CS: cs = 1'b0;
      D_STB: begin
        cs = 1'b0;
        if (write_q) begin
          wr     = 1'b0;
          ad_oe  = 1'b1;
          ad_out = wdata_q;
        end else begin
          rd = 1'b0;
        end
      end
      D_CSH: begin
        cs = 1'b0;
        if (write_q) begin
          ad_oe  = 1'b1;
          ad_out = wdata_q;
        end
      end
      default: ;
    endcase
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;

  a_no_wr_rd_overlap: assert property (@(posedge clock) disable iff (reset) !(!wr && !rd));
  a_no_rd_while_drive: assert property (@(posedge clock) disable iff (reset) !(!rd && ad_oe));

endmodule

// File: tb/tb_rtc_bus_master.sv
// Bench for rtc_bus_master: default-timing and minimum-timing instances checked cycle by cycle
// against a timeline model of the bus pins, driven from a vector table and random commands.
module tb_rtc_bus_master;

  logic       clock = 1'b0;
  logic       reset     [2];
  logic       cmd_valid [2];
  logic       cmd_ready [2];
  logic       cmd_write [2];
  logic [7:0] cmd_addr  [2];
  logic [7:0] cmd_wdata [2];
  logic       rsp_valid [2];
  logic [7:0] rsp_rdata [2];
  logic       busy      [2];
  logic [7:0] ad_out    [2];
  logic       ad_oe     [2];
  logic [7:0] ad_in     [2];
  logic       ad        [2];
  logic       cs        [2];
  logic       wr        [2];
  logic       rd        [2];

  int checks   = 0;
  int failures = 0;

  int ts_p [2] = '{5, 1};
  int tg_p [2] = '{8, 1};
  int tr_p [2] = '{8, 1};
  logic [7:0] rdata_exp [2] = '{8'h00, 8'h00};

  always #5 clock = ~clock;

  rtc_bus_master dut0 (
    .clock(clock), .reset(reset[0]), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_write(cmd_write[0]), .cmd_addr(cmd_addr[0]), .cmd_wdata(cmd_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .busy(busy[0]),
    .ad_out(ad_out[0]), .ad_oe(ad_oe[0]), .ad_in(ad_in[0]),
    .ad(ad[0]), .cs(cs[0]), .wr(wr[0]), .rd(rd[0])
  );

  rtc_bus_master #(.T_STB(1), .T_GAP(1), .T_REC(1)) dut1 (
    .clock(clock), .reset(reset[1]), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_write(cmd_write[1]), .cmd_addr(cmd_addr[1]), .cmd_wdata(cmd_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .busy(busy[1]),
    .ad_out(ad_out[1]), .ad_oe(ad_oe[1]), .ad_in(ad_in[1]),
    .ad(ad[1]), .cs(cs[1]), .wr(wr[1]), .rd(rd[1])
  );

  typedef struct packed {
    logic       p_ad;
    logic       p_cs;
    logic       p_wr;
    logic       p_rd;
    logic       p_oe;
    logic [7:0] p_dat;
  } pins_t;

  // Pin values k cycles after the accept edge, straight from the edge timeline (k < 0 = idle).
  function automatic pins_t model_pins(int k, bit w, logic [7:0] a, logic [7:0] d, int ts, int tg);
    pins_t p;
    int dcs, dstb, dend, dcsh_end, rel;
    rel      = 5 + ts;
    dcs      = 5 + ts + tg;
    dstb     = 6 + ts + tg;
    dend     = 6 + 2 * ts + tg;
    dcsh_end = 7 + 2 * ts + tg;
    p.p_ad  = !(k >= 0 && k < 4 + ts);
    p.p_cs  = !((k >= 1 && k < 3 + ts) || (k >= dcs && k < dcsh_end));
    p.p_wr  = !((k >= 2 && k < 2 + ts) || (w && k >= dstb && k < dend));
    p.p_rd  = !(!w && k >= dstb && k < dend);
    p.p_oe  = (k >= 2 && k < rel) || (w && k >= dstb && k < dcsh_end);
    p.p_dat = 8'hFF;
    if (k >= 2 && k < rel) p.p_dat = a;
    else if (w && k >= dstb && k < dcsh_end) p.p_dat = d;
    return p;
  endfunction

  task automatic check_cycle(input int u, input pins_t ep, input logic rv, input logic bz,
                             input logic rdy, input logic [7:0] rdx, input string tag);
    pins_t got;
    got = {ad[u], cs[u], wr[u], rd[u], ad_oe[u], ad_out[u]};
    checks++;
    if (got !== ep) begin
      failures++;
      $display("FAIL %s pins {ad,cs,wr,rd,oe,dat} got=%b_%h exp=%b_%h", tag,
               got[12:8], got[7:0], ep[12:8], ep[7:0]);
    end
    checks++;
    if ({rsp_valid[u], busy[u], cmd_ready[u], rsp_rdata[u]} !== {rv, bz, rdy, rdx}) begin
      failures++;
      $display("FAIL %s status {rsp_valid,busy,cmd_ready,rdata} got=%b%b%b_%h exp=%b%b%b_%h", tag,
               rsp_valid[u], busy[u], cmd_ready[u], rsp_rdata[u], rv, bz, rdy, rdx);
    end
  endtask

  task automatic idle(input int u, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
      ad_in[u] = 8'($urandom);
      check_cycle(u, model_pins(-1, 1'b0, 8'h00, 8'h00, ts_p[u], tg_p[u]), 1'b0, 1'b0, 1'b1,
                  rdata_exp[u], $sformatf("u%0d idle%0d", u, i));
    end
  endtask

  // Issues one command and checks every cycle up to and including the rsp_valid cycle.
  task automatic txn(input int u, input bit w, input logic [7:0] a, input logic [7:0] d,
                     input logic [7:0] din, input int glitch_k, input int abort_k);
    int ts, tg, tr, last, dstb, dend;
    logic [7:0] rdx;
    ts = ts_p[u]; tg = tg_p[u]; tr = tr_p[u];
    last = 7 + 2 * ts + tg + tr;
    dstb = 6 + ts + tg;
    dend = 6 + 2 * ts + tg;
    checks++;
    if (cmd_ready[u] !== 1'b1) begin
      failures++;
      $display("FAIL u%0d ready_before_accept got=%b exp=1", u, cmd_ready[u]);
    end
    cmd_valid[u] = 1'b1;
    cmd_write[u] = w;
    cmd_addr[u]  = a;
    cmd_wdata[u] = d;
    for (int k = 0; k <= last; k++) begin
      @(posedge clock); #1;
      if (k == 0) begin
        cmd_valid[u] = 1'b0;
        cmd_write[u] = 1'($urandom);
        cmd_addr[u]  = 8'($urandom);
        cmd_wdata[u] = 8'($urandom);
      end
      if (k == glitch_k) begin
        cmd_valid[u] = 1'b1;
        cmd_addr[u]  = ~a;
        cmd_write[u] = ~w;
      end else if (k == glitch_k + 1) begin
        cmd_valid[u] = 1'b0;
      end
      ad_in[u] = (!w && k >= dstb && k < dend) ? din : 8'($urandom);
      rdx = (!w && k >= dend) ? din : rdata_exp[u];
      check_cycle(u, model_pins(k, w, a, d, ts, tg), 1'(k == last), 1'(k < last), 1'(k == last),
                  rdx, $sformatf("u%0d a%h k%0d", u, a, k));
      if (k == abort_k) begin
        reset[u] = 1'b1;
        @(posedge clock); #1;
        reset[u] = 1'b0;
        rdata_exp[u] = 8'h00;
        check_cycle(u, model_pins(-1, 1'b0, 8'h00, 8'h00, ts, tg), 1'b0, 1'b0, 1'b1, 8'h00,
                    $sformatf("u%0d abort", u));
        return;
      end
    end
    if (!w) rdata_exp[u] = din;
  endtask

  typedef struct {
    int         u;
    bit         w;
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] din;
    bit         b2b;
    int         glitch_k;
    int         abort_k;
    logic [7:0] exp_rdata;
  } vec_t;

  initial begin
    vec_t vt [11];
    for (int u = 0; u < 2; u++) begin
      reset[u] = 1'b1; cmd_valid[u] = 1'b0; cmd_write[u] = 1'b0;
      cmd_addr[u] = 8'h00; cmd_wdata[u] = 8'h00; ad_in[u] = 8'h00;
    end

    //          u  w  addr   wdata  ad_in  b2b glitch abort rdata_after
    vt[0]  = '{0, 1, 8'h43, 8'h00, 8'h00, 0,  -1,  -1, 8'h00};
    vt[1]  = '{0, 0, 8'h0C, 8'h00, 8'h5A, 0,  -1,  -1, 8'h5A};
    vt[2]  = '{0, 1, 8'h43, 8'h00, 8'h00, 1,  -1,  -1, 8'h5A};
    vt[3]  = '{0, 1, 8'h42, 8'h00, 8'h00, 1,  -1,  -1, 8'h5A};
    vt[4]  = '{0, 1, 8'h41, 8'h00, 8'h00, 1,  -1,  -1, 8'h5A};
    vt[5]  = '{0, 1, 8'hF2, 8'hFF, 8'h00, 0,  -1,  -1, 8'h5A};
    vt[6]  = '{0, 1, 8'h20, 8'h77, 8'h00, 0,   5,  -1, 8'h5A};
    vt[7]  = '{1, 1, 8'h55, 8'hAA, 8'h00, 0,  -1,  -1, 8'h00};
    vt[8]  = '{1, 0, 8'h33, 8'h00, 8'hC3, 0,  -1,  -1, 8'hC3};
    vt[9]  = '{0, 1, 8'h10, 8'h11, 8'h00, 0,  -1,  20, 8'h00};
    vt[10] = '{0, 0, 8'h0D, 8'h00, 8'h99, 0,  -1,  -1, 8'h99};

    repeat (3) @(posedge clock);
    #1;
    for (int u = 0; u < 2; u++)
      check_cycle(u, model_pins(-1, 1'b0, 8'h00, 8'h00, ts_p[u], tg_p[u]), 1'b0, 1'b0, 1'b1,
                  8'h00, $sformatf("u%0d in_reset", u));
    reset[0] = 1'b0;
    reset[1] = 1'b0;
    idle(0, 2);
    idle(1, 1);

    for (int i = 0; i < 11; i++) begin
      txn(vt[i].u, vt[i].w, vt[i].a, vt[i].d, vt[i].din, vt[i].glitch_k, vt[i].abort_k);
      checks++;
      if (rsp_rdata[vt[i].u] !== vt[i].exp_rdata) begin
        failures++;
        $display("FAIL vec%0d rdata_after got=%h exp=%h", i, rsp_rdata[vt[i].u], vt[i].exp_rdata);
      end
      if (!vt[i].b2b) idle(vt[i].u, (vt[i].abort_k >= 0) ? 40 : 3);
    end

    for (int i = 0; i < 30; i++) begin
      int u;
      bit w, b2b;
      u   = int'($urandom_range(0, 1));
      w   = 1'($urandom);
      b2b = 1'($urandom);
      txn(u, w, 8'($urandom), 8'($urandom), 8'($urandom), -1, -1);
      if (!b2b) idle(u, int'($urandom_range(1, 4)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
